// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard decoder:
//   - key index constants (bit positions in keys_o) and NUM_KEYS
//   - scan code set 2 constants, including the E0 / F0 prefixes
//   - receiver state enum
//   - key_lookup(): maps a scan code (plus extended flag) to a key index
package ps2_pkg;

    localparam int NUM_KEYS  = 12;

    localparam int KEY_SPACE = 0;
    localparam int KEY_W     = 1;
    localparam int KEY_A     = 2;
    localparam int KEY_S     = 3;
    localparam int KEY_D     = 4;
    localparam int KEY_F     = 5;
    localparam int KEY_UP    = 6;
    localparam int KEY_DOWN  = 7;
    localparam int KEY_LEFT  = 8;
    localparam int KEY_RIGHT = 9;
    localparam int KEY_ENTER = 10;
    localparam int KEY_ESC   = 11;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_UP    = 8'h75;   // E0-prefixed; bare 75 is keypad 8
    localparam logic [7:0] SC_DOWN  = 8'h72;   // E0-prefixed
    localparam logic [7:0] SC_LEFT  = 8'h6B;   // E0-prefixed
    localparam logic [7:0] SC_RIGHT = 8'h74;   // E0-prefixed
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_hit_t;

    // Extended (E0) codes and plain codes live in separate tables, so the
    // same byte can mean different keys depending on the prefix.
    function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = '0;
        if (ext) begin
            case (code)
                SC_UP:    r.idx = 4'(KEY_UP);
                SC_DOWN:  r.idx = 4'(KEY_DOWN);
                SC_LEFT:  r.idx = 4'(KEY_LEFT);
                SC_RIGHT: r.idx = 4'(KEY_RIGHT);
                default:  r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_SPACE: r.idx = 4'(KEY_SPACE);
                SC_W:     r.idx = 4'(KEY_W);
                SC_A:     r.idx = 4'(KEY_A);
                SC_S:     r.idx = 4'(KEY_S);
                SC_D:     r.idx = 4'(KEY_D);
                SC_F:     r.idx = 4'(KEY_F);
                SC_ENTER: r.idx = 4'(KEY_ENTER);
                SC_ESC:   r.idx = 4'(KEY_ESC);
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx
// PS/2 frame receiver: pin synchronizers, falling-edge detect on the PS/2
// clock, 11-bit frame FSM (start, 8 data LSB first, parity, stop), and a
// mid-frame inactivity timeout.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity check; a mismatch
// drops the frame). Without it the parity bit is skipped.
// Ports:
//   clk_i, reset_ni      system clock, async active-low reset
//   ps2_clk_i            raw PS/2 clock pin (asynchronous)
//   ps2_data_i           raw PS/2 data pin (asynchronous)
//   byte_o               received byte, meaningful while valid_o is high
//   valid_o              one-cycle strobe: good frame received
//   err_o                one-cycle strobe: frame dropped (stop/parity/timeout)
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // clk_sync_q[1:0] is the two-flop synchronizer, clk_sync_q[2] the edge register.
    logic [2:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             fall;
    logic             data_bit;

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;
    logic             parity_ok;

    // NOTE: synchronizers reset to the bus idle level (high) so that leaving
    // reset never manufactures a falling edge on an idle line.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    // Odd parity: data bits plus the parity bit must contain an odd number of 1s.
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    assign tmo_hit = (state_q != RX_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));
    assign byte_o  = shift_q;

    // NOTE: every signal driven here gets a default first; otherwise a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = '0;
        valid_o   = 1'b0;
        err_o     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif

        if (tmo_hit) begin
            // Timeout takes precedence over a coincident edge.
            state_d = RX_IDLE;
            err_o   = 1'b1;
        end else begin
            if (state_q != RX_IDLE) begin
                tmo_d = fall ? '0 : tmo_q + 1'b1;
            end

            case (state_q)
                RX_IDLE: begin
                    if (fall && !data_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    if (fall) begin
                        shift_d = {data_bit, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RX_PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_d = data_bit;
`endif
                        state_d  = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (fall) begin
                        state_d = RX_IDLE;
                        if (data_bit && parity_ok) begin
                            valid_o = 1'b1;
                        end else begin
                            err_o = 1'b1;
                        end
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns PS/2 scan code set 2 frames into held key levels for the game.
// The ps2_rx sub-module delivers bytes; this level tracks the E0 (extended)
// and F0 (break) prefixes and keeps one level bit per mapped key.
// Optional feature macro: PS2_PARITY_CHECK_EN (forwarded to ps2_rx).
// Ports:
//   clk_i, reset_ni   system clock, async active-low reset
//   ps2_clk_i         raw PS/2 clock pin
//   ps2_data_i        raw PS/2 data pin
//   keys_o            held key levels, indexed by ps2_pkg KEY_* constants
//   space_o           keys_o[KEY_SPACE]
//   sellect_up_o      keys_o[KEY_UP]
//   sellect_down_o    keys_o[KEY_DOWN]
//   scan_valid_o      one-cycle pulse per good byte
//   scan_code_o       last good byte (held)
//   frame_err_o       one-cycle pulse per dropped frame
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                ps2_clk_i,
    input  logic                ps2_data_i,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                space_o,
    output logic                sellect_up_o,
    output logic                sellect_down_o,
    output logic                scan_valid_o,
    output logic [7:0]          scan_code_o,
    output logic                frame_err_o
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                rx_err;

    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                scan_valid_q;
    logic [7:0]          scan_code_q;
    logic                frame_err_q;
    key_hit_t            hit;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .err_o      (rx_err)
    );

    assign hit = key_lookup(rx_byte, ext_q);

    always_comb begin
        keys_d = keys_q;
        ext_d  = ext_q;
        brk_d  = brk_q;

        if (rx_err) begin
            // A dropped frame may have been the key byte a prefix belonged to.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                // Writing a level (not toggling) makes typematic repeats harmless.
                if (hit.hit) begin
                    keys_d[hit.idx] = ~brk_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            keys_q       <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_code_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            keys_q       <= keys_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            scan_valid_q <= rx_valid;
            frame_err_q  <= rx_err;
            if (rx_valid) begin
                scan_code_q <= rx_byte;
            end
        end
    end

    assign keys_o         = keys_q;
    assign space_o        = keys_q[KEY_SPACE];
    assign sellect_up_o   = keys_q[KEY_UP];
    assign sellect_down_o = keys_q[KEY_DOWN];
    assign scan_valid_o   = scan_valid_q;
    assign scan_code_o    = scan_code_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder: a table of scan-code frames with the
// expected key levels after each, followed by hand-written sequences for
// parity error, bad stop bit, mid-frame timeout and mid-frame reset.
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int unsigned TMO  = 300;
    localparam int          HALF = 10;   // system cycles per PS/2 half-period

    logic                clk_i      = 1'b0;
    logic                reset_ni   = 1'b0;
    logic                ps2_clk_i  = 1'b1;
    logic                ps2_data_i = 1'b1;
    logic [NUM_KEYS-1:0] keys_o;
    logic                space_o;
    logic                sellect_up_o;
    logic                sellect_down_o;
    logic                scan_valid_o;
    logic [7:0]          scan_code_o;
    logic                frame_err_o;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .ps2_clk_i      (ps2_clk_i),
        .ps2_data_i     (ps2_data_i),
        .keys_o         (keys_o),
        .space_o        (space_o),
        .sellect_up_o   (sellect_up_o),
        .sellect_down_o (sellect_down_o),
        .scan_valid_o   (scan_valid_o),
        .scan_code_o    (scan_code_o),
        .frame_err_o    (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters sampled on the inactive edge; a stretched pulse counts twice.
    always @(negedge clk_i) begin
        if (scan_valid_o) valid_cnt++;
        if (frame_err_o)  err_cnt++;
    end

    typedef struct {
        logic [7:0]  code;
        logic [11:0] keys;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data_i = b;
        cycles(HALF);
        ps2_clk_i = 1'b0;
        cycles(HALF);
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^code) ^ flip_par, code, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        ps2_data_i = 1'b1;
        cycles(HALF);
    endtask

    task automatic check_levels(input string tag, input logic [11:0] exp);
        check({tag, "_keys"}, 32'(keys_o), 32'(exp));
        check({tag, "_space"}, 32'(space_o), 32'(exp[KEY_SPACE]));
        check({tag, "_up"}, 32'(sellect_up_o), 32'(exp[KEY_UP]));
        check({tag, "_down"}, 32'(sellect_down_o), 32'(exp[KEY_DOWN]));
    endtask

    initial begin
        int v0;
        int e0;

        vecs[0]  = '{8'h29, 12'h001};
        vecs[1]  = '{8'hF0, 12'h001};
        vecs[2]  = '{8'h29, 12'h000};
        vecs[3]  = '{8'hE0, 12'h000};
        vecs[4]  = '{8'h75, 12'h040};
        vecs[5]  = '{8'hE0, 12'h040};
        vecs[6]  = '{8'hF0, 12'h040};
        vecs[7]  = '{8'h75, 12'h000};
        vecs[8]  = '{8'h75, 12'h000};   // keypad 8, unmapped
        vecs[9]  = '{8'h1D, 12'h002};
        vecs[10] = '{8'hE0, 12'h002};
        vecs[11] = '{8'h75, 12'h042};
        vecs[12] = '{8'hF0, 12'h042};
        vecs[13] = '{8'h1D, 12'h040};
        vecs[14] = '{8'h1D, 12'h042};
        vecs[15] = '{8'h1D, 12'h042};
        vecs[16] = '{8'h1D, 12'h042};
        vecs[17] = '{8'hE0, 12'h042};
        vecs[18] = '{8'h72, 12'h0C2};
        vecs[19] = '{8'hE0, 12'h0C2};
        vecs[20] = '{8'hF0, 12'h0C2};
        vecs[21] = '{8'h72, 12'h042};
        vecs[22] = '{8'h5A, 12'h442};
        vecs[23] = '{8'hF0, 12'h442};
        vecs[24] = '{8'h5A, 12'h042};
        vecs[25] = '{8'hF0, 12'h042};
        vecs[26] = '{8'h1D, 12'h040};

        // Reset state
        cycles(5);
        reset_ni = 1'b1;
        cycles(10);
        check_levels("reset", 12'h000);
        check("reset_valid", 32'(scan_valid_o), 0);
        check("reset_code", 32'(scan_code_o), 0);
        check("reset_err", 32'(frame_err_o), 0);
        check("reset_pulses", 32'(valid_cnt + err_cnt), 0);

        // Table-driven frames
        for (int i = 0; i < 27; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].code, 1'b0, 1'b0);
            check_levels($sformatf("vec%0d", i), vecs[i].keys);
            check($sformatf("vec%0d_code", i), 32'(scan_code_o), 32'(vecs[i].code));
            check($sformatf("vec%0d_vpulse", i), 32'(valid_cnt - v0), 1);
            check($sformatf("vec%0d_epulse", i), 32'(err_cnt - e0), 0);
        end

        // Parity-flipped 1D
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h1D, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("par_keys", 32'(keys_o), 32'h040);
        check("par_err", 32'(err_cnt - e0), 1);
        check("par_valid", 32'(valid_cnt - v0), 0);
`else
        check("par_keys", 32'(keys_o), 32'h042);
        check("par_err", 32'(err_cnt - e0), 0);
        check("par_valid", 32'(valid_cnt - v0), 1);
`endif
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        check("par_release", 32'(keys_o), 32'h040);

        // Bad stop bit: dropped, keys untouched
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b1);
        check("stop_err", 32'(err_cnt - e0), 1);
        check("stop_valid", 32'(valid_cnt - v0), 0);
        check("stop_keys", 32'(keys_o), 32'h040);

        // Mid-frame timeout: start bit + 4 data bits, then silence
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_data_i = 1'b1;
        cycles(int'(TMO) + 20);
        check("tmo_err", 32'(err_cnt - e0), 1);
        check("tmo_valid", 32'(valid_cnt - v0), 0);
        send_frame(8'h23, 1'b0, 1'b0);
        check("tmo_next_d", 32'(keys_o[KEY_D]), 1);
        check("tmo_next_keys", 32'(keys_o), 32'h050);

        // E0 then reset in the middle of the next frame
        send_frame(8'hE0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        reset_ni = 1'b0;
        #1;
        check_levels("rst", 12'h000);
        check("rst_valid", 32'(scan_valid_o), 0);
        check("rst_code", 32'(scan_code_o), 0);
        check("rst_err", 32'(frame_err_o), 0);
        cycles(5);
        reset_ni = 1'b1;
        cycles(5);
        v0 = valid_cnt;
        send_frame(8'h72, 1'b0, 1'b0);
        check("rst_72_keys", 32'(keys_o), 32'h000);
        check("rst_72_valid", 32'(valid_cnt - v0), 1);
        check("rst_72_code", 32'(scan_code_o), 32'h72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
